// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder and its word array.
// The out-of-range read pattern applies only to builds that define MEM_ADDR_CHECK_EN.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [31:0] BAD_ADDR_VAL  = 32'hDEADBEEF;
    localparam int          DEF_DATA_W    = 32;
    localparam int          DEF_ADDR_BITS = 8;
    localparam int          DEF_LATENCY   = 4;

endpackage

// File: rtl/mem_word_array.sv
// Single-port synchronous word store with write enable and a read-enabled output register.
// The contents have no reset.
module mem_word_array #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_BITS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// Wait-state memory responder on the mem_* four-phase handshake.
// Define MEM_ADDR_CHECK_EN to reject accesses with nonzero address bits above ADDR_BITS.
module main_memory_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       mem_addr,
    input  logic              mem_read_en,
    input  logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_write_val,
    output logic [DATA_W-1:0] mem_read_val,
    output logic              mem_response
);

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   resp_q, resp_d;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [DATA_W-1:0]      wval_q;
    logic                   rd_q, wr_q;
    logic [DATA_W-1:0]      alt_q, alt_d;
    logic                   sel_alt_q, sel_alt_d;

    logic                   req, in_idle, resp_entry;
    logic [ADDR_BITS-1:0]   acc_addr;
    logic [DATA_W-1:0]      acc_wval;
    logic                   acc_rd, acc_wr, acc_bad;
    logic                   ram_we, ram_re;
    logic [DATA_W-1:0]      ram_rdata;

    assign req     = mem_read_en | mem_write_en;
    assign in_idle = (state_q == IDLE);

    // With LATENCY=1 the access completes at the accept edge, before capture lands.
    assign acc_addr = in_idle ? mem_addr[ADDR_BITS-1:0] : addr_q;
    assign acc_wval = in_idle ? mem_write_val : wval_q;
    assign acc_rd   = in_idle ? mem_read_en : rd_q;
    assign acc_wr   = in_idle ? mem_write_en : wr_q;

`ifdef MEM_ADDR_CHECK_EN
    logic bad_q;
    logic bad_in;

    assign bad_in  = |mem_addr[31:ADDR_BITS];
    assign acc_bad = in_idle ? bad_in : bad_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bad_q <= 1'b0;
        end else if (in_idle && req) begin
            bad_q <= bad_in;
        end
    end
`else
    logic unused_addr_hi;

    assign unused_addr_hi = ^mem_addr[31:ADDR_BITS];
    assign acc_bad        = 1'b0;
`endif

    assign resp_entry = reset_n && req &&
                        ((in_idle && (LATENCY == 1)) || (state_q == WAIT && cnt_q == 8'd0));

    assign ram_we = resp_entry && acc_wr && !acc_bad;
    assign ram_re = resp_entry && acc_rd && !acc_wr && !acc_bad;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (!req) begin
                    state_d = DROP;
                end
            end
            DROP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        resp_d = resp_q;
        if (resp_entry) begin
            resp_d = 1'b1;
        end else if (state_q == RESP && !req) begin
            resp_d = 1'b0;
        end
    end

    // Read data comes either from the array register or from alt_q (write-through / bad address).
    always_comb begin
        alt_d     = alt_q;
        sel_alt_d = sel_alt_q;
        if (resp_entry && acc_rd && (acc_wr || acc_bad)) begin
            alt_d     = acc_bad ? DATA_W'(BAD_ADDR_VAL) : acc_wval;
            sel_alt_d = 1'b1;
        end else if (ram_re) begin
            sel_alt_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            resp_q    <= 1'b0;
            alt_q     <= '0;
            sel_alt_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            alt_q     <= alt_d;
            sel_alt_q <= sel_alt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            wval_q <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
        end else if (in_idle && req) begin
            addr_q <= mem_addr[ADDR_BITS-1:0];
            wval_q <= mem_write_val;
            rd_q   <= mem_read_en;
            wr_q   <= mem_write_en;
        end
    end

    mem_word_array #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (DATA_W)
    ) u_array (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (acc_addr),
        .wdata_i (acc_wval),
        .rdata_o (ram_rdata)
    );

    assign mem_read_val = sel_alt_q ? alt_q : ram_rdata;
    assign mem_response = resp_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder at LATENCY=4; honours MEM_ADDR_CHECK_EN when defined.
module tb_main_memory_responder;

    localparam int LAT = 4;

    logic        clk;
    logic        reset_n;
    logic [31:0] mem_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_write_val;
    logic [31:0] mem_read_val;
    logic        mem_response;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_rv;

    main_memory_responder #(
        .ADDR_BITS (8),
        .DATA_W    (32),
        .LATENCY   (LAT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_addr      (mem_addr),
        .mem_read_en   (mem_read_en),
        .mem_write_en  (mem_write_en),
        .mem_write_val (mem_write_val),
        .mem_read_val  (mem_read_val),
        .mem_response  (mem_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full handshake. early=1 raises the request before the DROP edge, which must not accept it.
    task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] val, input logic chk, input logic [31:0] exp_rv,
                       input logic early, input string tag);
        int hits;
        if (!early) step();
        mem_read_en   = rd;
        mem_write_en  = wr;
        mem_addr      = addr;
        mem_write_val = val;
        step();
        if (early) step();
        mem_addr      = ~addr;
        mem_write_val = ~val;
        hits = 0;
        for (int k = 1; k < LAT; k++) begin
            step();
            if (mem_response !== 1'b0) hits++;
        end
        check({tag, "_early_resp"}, 32'(hits), 32'd0);
        step();
        check({tag, "_resp_rise"}, {31'd0, mem_response}, 32'd1);
        if (chk) model_rv = exp_rv;
        check({tag, "_rv"}, mem_read_val, model_rv);
        step();
        check({tag, "_resp_hold"}, {31'd0, mem_response}, 32'd1);
        check({tag, "_rv_hold"}, mem_read_val, model_rv);
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        step();
        check({tag, "_resp_fall"}, {31'd0, mem_response}, 32'd0);
        $display("txn %s rd=%0b wr=%0b addr=%h wval=%h read_val=%h", tag, rd, wr, addr, val, mem_read_val);
    endtask

    initial begin
        int hits;
        reset_n       = 1'b0;
        mem_addr      = 32'd0;
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;
        mem_write_val = 32'd0;
        model_rv      = 32'd0;
        repeat (3) step();
        check("rst_resp", {31'd0, mem_response}, 32'd0);
        check("rst_rv", mem_read_val, 32'd0);
        reset_n = 1'b1;

        // Basic write then read, latency and handshake edges
        req(1'b0, 1'b1, 32'd0, 32'd1, 1'b0, 32'd0, 1'b0, "t1_wr0");
        req(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, "t1_rd0");

        // Back-to-back sweep, each request raised during the DROP cycle
        for (int i = 0; i < 8; i++)
            req(1'b0, 1'b1, 32'(i), 32'(i + 1), 1'b0, 32'd0, 1'b1, "t2_wr");
        for (int i = 0; i < 8; i++)
            req(1'b1, 1'b0, 32'(i), 32'd0, 1'b1, 32'(i + 1), 1'b1, "t2_rd");

        // Abort a read mid-wait, then reissue it
        req(1'b0, 1'b1, 32'd3, 32'd4, 1'b0, 32'd0, 1'b0, "t3_wr3");
        step();
        mem_read_en = 1'b1;
        mem_addr    = 32'd3;
        step();
        step();
        step();
        mem_read_en = 1'b0;
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (mem_response !== 1'b0) hits++;
        end
        check("t3_abort_resp", 32'(hits), 32'd0);
        check("t3_abort_rv", mem_read_val, 32'd8);
        $display("txn t3_abort rd=1 wr=0 addr=00000003 read_val=%h", mem_read_val);
        req(1'b1, 1'b0, 32'd3, 32'd0, 1'b1, 32'd4, 1'b0, "t3_rd3");

        // Both enables: write wins and the written value is returned
        req(1'b1, 1'b1, 32'd5, 32'd9, 1'b1, 32'd9, 1'b0, "t4_both5");
        req(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, "t4_rd0");
        req(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 32'd9, 1'b0, "t4_rd5");

        // Upper address bits
        req(1'b0, 1'b1, 32'd258, 32'd7, 1'b0, 32'd0, 1'b0, "t5_wr258");
`ifdef MEM_ADDR_CHECK_EN
        req(1'b1, 1'b0, 32'd258, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, "t5_rd258");
        req(1'b1, 1'b0, 32'd2, 32'd0, 1'b1, 32'd3, 1'b0, "t5_rd2");
`else
        req(1'b1, 1'b0, 32'd258, 32'd0, 1'b1, 32'd7, 1'b0, "t5_rd258");
        req(1'b1, 1'b0, 32'd2, 32'd0, 1'b1, 32'd7, 1'b0, "t5_rd2");
`endif

        // Reset while a write is waiting
        step();
        mem_write_en  = 1'b1;
        mem_addr      = 32'd1;
        mem_write_val = 32'h55;
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("t6_rst_resp", {31'd0, mem_response}, 32'd0);
        check("t6_rst_rv", mem_read_val, 32'd0);
        model_rv     = 32'd0;
        mem_write_en = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        $display("txn t6_reset wr=1 addr=00000001 read_val=%h", mem_read_val);
        req(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 32'd2, 1'b0, "t6_rd1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
